// File: rtl/adpll_tdc_pkg.sv
// Shared definitions for the ADPLL TDC post-processing path.
package adpll_tdc_pkg;

  localparam int unsigned TDC_CNT_W    = 7;
  localparam int unsigned TDC_PHASE_W  = 20;
  localparam int unsigned TDC_AVG_LOG2 = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } tdc_unwrap_state_t;

endpackage

// File: rtl/tdc_freq_avg.sv
// Windowed frequency averager: sums 2^AVG_LOG2 consecutive deltas per output.
module tdc_freq_avg
  import adpll_tdc_pkg::*;
#(
  parameter int unsigned CNT_W    = TDC_CNT_W,
  parameter int unsigned AVG_LOG2 = TDC_AVG_LOG2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CNT_W-1:0]          d,
  input  logic                      upd,
  input  logic                      clr,
  output logic [CNT_W+AVG_LOG2-1:0] freq_avg,
  output logic                      freq_valid
);

  localparam int unsigned AVG_W = CNT_W + AVG_LOG2;

  logic [AVG_LOG2-1:0] k_q;
  logic [AVG_W-1:0]    acc_q;
  logic [AVG_W-1:0]    sum_c;

  // Full-window sum of 2^AVG_LOG2 values below 2^CNT_W always fits AVG_W bits.
  assign sum_c = acc_q + AVG_W'(d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q        <= '0;
      acc_q      <= '0;
      freq_avg   <= '0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (clr) begin
        k_q   <= '0;
        acc_q <= '0;
      end else if (upd) begin
        if (&k_q) begin
          freq_avg   <= sum_c;
          freq_valid <= 1'b1;
          acc_q      <= '0;
          k_q        <= '0;
        end else begin
          acc_q <= sum_c;
          k_q   <= k_q + AVG_LOG2'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tdc_count_unwrap.sv
// Retimes the TDC ripple count, unwraps modulo-2^CNT_W deltas into a wide
// integer phase and feeds the windowed frequency averager.
module tdc_count_unwrap
  import adpll_tdc_pkg::*;
#(
  parameter int unsigned CNT_W    = TDC_CNT_W,
  parameter int unsigned PHASE_W  = TDC_PHASE_W,
  parameter int unsigned AVG_LOG2 = TDC_AVG_LOG2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      phase_clr,
  input  logic [CNT_W-1:0]          count,
  output logic [CNT_W-1:0]          delta,
  output logic                      delta_valid,
  output logic [PHASE_W-1:0]        phase_int,
  output logic [CNT_W+AVG_LOG2-1:0] freq_avg,
  output logic                      freq_valid
);

  tdc_unwrap_state_t state_q, state_d;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] prev_q;
  logic [CNT_W-1:0] d_c;
  logic             upd_c;
  logic             prime_c;
  logic             leave_c;

  // Modulo subtraction absorbs a single counter wrap between samples.
  assign d_c = count_q - prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    upd_c   = 1'b0;
    prime_c = 1'b0;
    leave_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        prime_c = 1'b1;
        state_d = en ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (en) begin
          upd_c = 1'b1;
        end else begin
          leave_c = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      prev_q      <= '0;
      delta       <= '0;
      delta_valid <= 1'b0;
      phase_int   <= '0;
    end else begin
      count_q     <= count;
      delta_valid <= upd_c;
      if (prime_c || upd_c) prev_q <= count_q;
      if (upd_c) delta <= d_c;
      // A clear that coincides with an update keeps the current delta.
      if (upd_c) begin
        if (phase_clr) phase_int <= PHASE_W'(d_c);
        else           phase_int <= phase_int + PHASE_W'(d_c);
      end else if (phase_clr) begin
        phase_int <= '0;
      end
    end
  end

  tdc_freq_avg #(
    .CNT_W    (CNT_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_freq_avg (
    .clk        (clk),
    .rst        (rst),
    .d          (d_c),
    .upd        (upd_c),
    .clr        (leave_c),
    .freq_avg   (freq_avg),
    .freq_valid (freq_valid)
  );

endmodule

// File: tb/tb_tdc_count_unwrap.sv
// Randomized and directed bench for tdc_count_unwrap against an en-streak model.
module tb_tdc_count_unwrap;

  localparam int unsigned CW  = 7;
  localparam int unsigned PW  = 20;
  localparam int unsigned AL  = 3;
  localparam int unsigned FW  = CW + AL;
  localparam int unsigned WIN = 1 << AL;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          phase_clr;
  logic [CW-1:0] count;

  logic [CW-1:0] delta,  delta8;
  logic          dv,     dv8;
  logic [PW-1:0] phase;
  logic [7:0]    phase8;
  logic [FW-1:0] favg,   favg8;
  logic          fv,     fv8;

  tdc_count_unwrap u_dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .phase_clr   (phase_clr),
    .count       (count),
    .delta       (delta),
    .delta_valid (dv),
    .phase_int   (phase),
    .freq_avg    (favg),
    .freq_valid  (fv)
  );

  tdc_count_unwrap #(.PHASE_W(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .phase_clr   (phase_clr),
    .count       (count),
    .delta       (delta8),
    .delta_valid (dv8),
    .phase_int   (phase8),
    .freq_avg    (favg8),
    .freq_valid  (fv8)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Model state: an update happens on an edge iff en was sampled high on
  // this edge and the two before it; the delta spans the two prior samples.
  int            streak;
  logic [CW-1:0] c1, c2;
  logic [CW-1:0] m_delta;
  logic          m_dv;
  logic [PW-1:0] m_phase;
  logic [FW-1:0] m_favg;
  logic          m_fv;
  logic [CW-1:0] win[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    streak  = 0;
    c1      = '0;
    c2      = '0;
    m_delta = '0;
    m_dv    = 1'b0;
    m_phase = '0;
    m_favg  = '0;
    m_fv    = 1'b0;
    win.delete();
  endtask

  task automatic model_edge(input logic e, input logic c, input logic [CW-1:0] k);
    logic [CW-1:0] d;
    int            s;
    streak = e ? streak + 1 : 0;
    if (!e) win.delete();
    m_fv = 1'b0;
    if (e && streak >= 3) begin
      d       = c1 - c2;
      m_delta = d;
      m_dv    = 1'b1;
      m_phase = c ? PW'(d) : m_phase + PW'(d);
      win.push_back(d);
      if (win.size() == WIN) begin
        s = 0;
        foreach (win[i]) s += int'(win[i]);
        m_favg = FW'(s);
        m_fv   = 1'b1;
        win.delete();
      end
    end else begin
      m_dv = 1'b0;
      if (c) m_phase = '0;
    end
    c2 = c1;
    c1 = k;
  endtask

  task automatic check_all();
    check("delta",       32'(delta),  32'(m_delta));
    check("delta_valid", 32'(dv),     32'(m_dv));
    check("phase_int",   32'(phase),  32'(m_phase));
    check("freq_avg",    32'(favg),   32'(m_favg));
    check("freq_valid",  32'(fv),     32'(m_fv));
    check("delta_w8",    32'(delta8), 32'(m_delta));
    check("dvalid_w8",   32'(dv8),    32'(m_dv));
    check("phase_w8",    32'(phase8), 32'(m_phase[7:0]));
    check("favg_w8",     32'(favg8),  32'(m_favg));
    check("fvalid_w8",   32'(fv8),    32'(m_fv));
  endtask

  // Called at a falling edge; applies inputs for the next rising edge.
  task automatic step(input logic e, input logic c, input logic [CW-1:0] k);
    en        = e;
    phase_clr = c;
    count     = k;
    model_edge(e, c, k);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_delta"}, 32'(delta), 32'd0);
    check({tag, "_dv"},    32'(dv),    32'd0);
    check({tag, "_phase"}, 32'(phase), 32'd0);
    check({tag, "_favg"},  32'(favg),  32'd0);
    check({tag, "_fv"},    32'(fv),    32'd0);
  endtask

  // Asynchronous reset pulse between edges.
  task automatic reset_mid();
    #1 rst = 1'b1;
    #1 check_zero("rst_mid");
    model_reset();
    #1 rst = 1'b0;
  endtask

  logic [CW-1:0] cv;

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    phase_clr = 1'b0;
    count     = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Constant ratio +37 from 0; step i drives the count sampled at edge Ei.
    cv = '0;
    for (int i = 0; i <= 20; i++) begin
      step(1'b1, 1'b0, cv);
      cv = cv + CW'(37);
      if (i == 1)  check("const_no_dv_e1", 32'(dv), 32'd0);
      if (i == 2)  check("const_delta_e2", 32'(delta), 32'd37);
      if (i == 9)  check("const_fv_e9", 32'(fv), 32'd1);
      if (i == 9)  check("const_favg", 32'(favg), 32'd296);
      if (i == 11) check("const_phase10", 32'(phase), 32'd370);
    end

    // Enable gap: count moves by 60 while disabled.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, cv);
      cv = cv + CW'(12);
      check("gap_no_dv", 32'(dv), 32'd0);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, cv);
      cv = cv + CW'(37);
      if (i == 2) check("gap_first_delta", 32'(delta), 32'd37);
    end

    // Counter wrap 120 -> 5.
    step(1'b1, 1'b0, CW'(120));
    step(1'b1, 1'b0, CW'(5));
    step(1'b1, 1'b0, CW'(10));
    check("wrap_delta", 32'(delta), 32'd13);
    step(1'b1, 1'b0, CW'(15));

    // phase_clr with a RUN update, then on an idle cycle.
    step(1'b1, 1'b0, CW'(52));
    step(1'b1, 1'b0, CW'(89));
    step(1'b1, 1'b1, CW'(126));
    check("clr_run_phase", 32'(phase), 32'd37);
    step(1'b0, 1'b0, CW'(0));
    step(1'b0, 1'b1, CW'(0));
    check("clr_idle_phase", 32'(phase), 32'd0);
    step(1'b0, 1'b0, CW'(0));

    // 8-bit phase wrap with delta 100.
    cv = CW'(3);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, cv);
      cv = cv + CW'(100);
    end
    step(1'b1, 1'b1, cv); cv = cv + CW'(100);
    check("pw8_100", 32'(phase8), 32'd100);
    step(1'b1, 1'b0, cv); cv = cv + CW'(100);
    check("pw8_200", 32'(phase8), 32'd200);
    step(1'b1, 1'b0, cv); cv = cv + CW'(100);
    check("pw8_44", 32'(phase8), 32'd44);

    // Reset mid-run, then restart latency.
    reset_mid();
    step(1'b1, 1'b0, cv); cv = cv + CW'(21);
    check("rst_restart_e0", 32'(dv), 32'd0);
    step(1'b1, 1'b0, cv); cv = cv + CW'(21);
    check("rst_restart_e1", 32'(dv), 32'd0);
    step(1'b1, 1'b0, cv); cv = cv + CW'(21);
    check("rst_restart_e2", 32'(dv), 32'd1);
    check("rst_restart_d", 32'(delta), 32'd21);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) reset_mid();
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0), cv);
      cv = cv + CW'($urandom_range(0, 127));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
